stitch_sb_tag_pool: RTL and testbench
=====================================

# stitch_sb_tag_pool

Parametrised free-list of scoreboard tags for the stitch core. Holds every unallocated tag ID in FIFO order, hands tags out over a valid/ready allocate port, and takes them back over a release port. Successor to the fixed one-hot index pool: arbitrary tag count, binary and one-hot outputs, a full-width free count, a low-water flag, flush, and optional double-free detection.

## Interface
- NumTags, default 8: number of tags, 1 to 256.
- LowWater, default 1: `almost_empty_o` asserts when the free count is at or below this value.
- TagWidth, default (NumTags > 1) ? $clog2(NumTags) : 1: derived; do not override.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  returns the pool to its reset state at the next edge.
- alloc_valid_o  out  1  a free tag is available.
- alloc_ready_i  in  1  consumer takes the head tag.
- alloc_tag_o  out  TagWidth  head tag, binary.
- alloc_onehot_o  out  NumTags  head tag, one-hot; zero when `alloc_valid_o` is low.
- release_valid_i  in  1  tag returned this cycle.
- release_tag_i  in  TagWidth  tag being returned.
- release_ready_o  out  1  constant 1.
- free_cnt_o  out  TagWidth+1  number of free tags, 0..NumTags.
- almost_empty_o  out  1  free_cnt_o <= LowWater.
- err_double_free_o  out  1  one-cycle error pulse (see Configuration).
- err_tag_o  out  TagWidth  tag that caused the last error.

## Operation
- Storage: NumTags-entry circular buffer of TagWidth-bit IDs, read pointer `rd`, write pointer `wr`, and a (TagWidth+1)-bit count `cnt`.
- Reset or flush:
  - entry i holds i; rd = 0; wr = 0; cnt = NumTags.
  - alloc_tag_o = 0, alloc_onehot_o = 1, alloc_valid_o = 1, free_cnt_o = NumTags.
  - err_double_free_o = 0, err_tag_o = 0. The in-use map is cleared.
- Allocate fires on alloc_valid_o & alloc_ready_i. rd advances; cnt decrements.
- alloc_valid_o = (cnt != 0), driven only from registered state. There is no release-to-alloc bypass.
- Release is accepted when release_valid_i is high, release_tag_i < NumTags, and the error check (if compiled in) passes.
  - An accepted release writes mem[wr]; wr advances; cnt increments.
- Pointer wrap: at NumTags-1 a pointer returns to 0. This is explicit, so non-power-of-two NumTags works.
- Allocate and release in the same cycle: both take effect and cnt is unchanged.
- Release when cnt == NumTags is a protocol violation. The release is dropped, and flagged if the check is built in.
- Release with tag >= NumTags is always dropped.
- flush_i has priority over alloc and release in the same cycle. Neither is performed. alloc_valid_o is still driven from pre-flush state that cycle.
- Tags are allocated in the order they were released (FIFO). After reset the order is 0, 1, ..., NumTags-1.

## Timing
- alloc_tag_o, alloc_onehot_o and alloc_valid_o are registered-state outputs with no combinational path from any input.
- A released tag can be allocated from the next cycle at the earliest, and only once it reaches the head.
- free_cnt_o and almost_empty_o update one edge after the handshake.
- err_double_free_o and err_tag_o are registered and appear one cycle after the offending release. err_tag_o holds its value until the next error, reset or flush.
- Deasserting rst_ni mid-operation discards all state at that edge. Allocations outstanding at reset are forgotten.

## Configuration
- `STITCH_SB_TAG_POOL_DOUBLE_FREE_CHECK_EN` defined:
  - An NumTags-bit in-use map is kept. Allocate sets the bit; an accepted release clears it.
  - A release is rejected, and err_double_free_o pulses, in any of these cases:
    - the tag's bit is clear;
    - the tag is >= NumTags;
    - cnt == NumTags.
  - A release of the tag being allocated in the same cycle sees the pre-allocate map and is therefore rejected.
- Undefined:
  - No in-use map.
  - Releases of in-range tags with cnt < NumTags are always accepted.
  - err_double_free_o and err_tag_o are tied to 0.

## Test plan
- Reset, then hold alloc_ready_i high for 9 cycles with NumTags=8. Required response:
  - tags 0..7 are issued in order with alloc_onehot_o matching;
  - alloc_valid_o drops after the 8th allocation;
  - free_cnt_o = 0 and almost_empty_o = 1.
- Allocate all 8 tags, release 5, then 2. Required response:
  - alloc_valid_o rises the cycle after release 5;
  - alloc_tag_o = 5, then 2.
- At cnt = 0, release 3 and assert alloc_ready_i in the same cycle. Required response:
  - no allocation that cycle;
  - next cycle alloc_tag_o = 3 and free_cnt_o = 1.
- NumTags=6: allocate and release continuously for 20 cycles. Required response:
  - pointers wrap at 5 to 0;
  - tag order is preserved;
  - free_cnt_o never exceeds 6.
- With the check enabled, release tag 4 while it is free. Required response:
  - next cycle err_double_free_o = 1 and err_tag_o = 4;
  - free_cnt_o is unchanged.
  - With the macro undefined, the same release at cnt = 7 yields free_cnt_o = 8 and no error.
- Allocate 3 tags, then pulse flush_i together with alloc_ready_i and release_valid_i. Required response:
  - next cycle free_cnt_o = 8 and alloc_tag_o = 0;
  - err_double_free_o = 0.

Source files
------------

// File: rtl/stitch_sb_tag_pool.sv
// stitch_sb_tag_pool: FIFO free-list of scoreboard tags with valid/ready allocate and release ports.
//   Params : NumTags (1..256), LowWater (almost-empty threshold), TagWidth (derived, do not override).
//   Inputs : clk_i, rst_ni (sync, active-low), flush_i, alloc_ready_i, release_valid_i, release_tag_i.
//   Outputs: alloc_valid_o, alloc_tag_o, alloc_onehot_o, release_ready_o, free_cnt_o,
//            almost_empty_o, err_double_free_o, err_tag_o.
//   Define STITCH_SB_TAG_POOL_DOUBLE_FREE_CHECK_EN to build the in-use map and double-free detection.
module stitch_sb_tag_pool #(
  parameter int NumTags  = 8,
  parameter int LowWater = 1,
  parameter int TagWidth = (NumTags > 1) ? $clog2(NumTags) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                alloc_valid_o,
  input  logic                alloc_ready_i,
  output logic [TagWidth-1:0] alloc_tag_o,
  output logic [NumTags-1:0]  alloc_onehot_o,
  input  logic                release_valid_i,
  input  logic [TagWidth-1:0] release_tag_i,
  output logic                release_ready_o,
  output logic [TagWidth:0]   free_cnt_o,
  output logic                almost_empty_o,
  output logic                err_double_free_o,
  output logic [TagWidth-1:0] err_tag_o
);
  localparam logic [TagWidth:0] Full = (TagWidth+1)'(NumTags);
  logic [TagWidth-1:0] mem [NumTags];
  logic [TagWidth-1:0] rd, wr;
  logic [TagWidth:0]   cnt;
  logic                alloc_fire, rel_ok, rel_fire;
  // Explicit wrap so non-power-of-two pools cycle correctly.
  function automatic logic [TagWidth-1:0] inc(input logic [TagWidth-1:0] p);
    return (32'(p) == NumTags - 1) ? '0 : p + 1'b1;
  endfunction
  assign alloc_valid_o   = cnt != '0;
  assign alloc_tag_o     = mem[rd];
  assign alloc_fire      = alloc_valid_o & alloc_ready_i;
  assign release_ready_o = 1'b1;
  assign free_cnt_o      = cnt;
  assign almost_empty_o  = 32'(cnt) <= LowWater;
  assign rel_ok          = release_valid_i && ({1'b0, release_tag_i} < Full) && (cnt != Full);
  always_comb begin
    alloc_onehot_o = '0;
    alloc_onehot_o[mem[rd]] = alloc_valid_o;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < NumTags; i++) mem[i] <= TagWidth'(i);
      rd  <= '0;
      wr  <= '0;
      cnt <= Full;
    end else begin
      if (rel_fire) begin
        mem[wr] <= release_tag_i;
        wr      <= inc(wr);
      end
      if (alloc_fire) rd <= inc(rd);
      cnt <= cnt + (TagWidth+1)'(rel_fire) - (TagWidth+1)'(alloc_fire);
    end
  end
`ifdef STITCH_SB_TAG_POOL_DOUBLE_FREE_CHECK_EN
  logic [NumTags-1:0] in_use, rel_mask;
  logic               rel_bad;
  // The map is read before this cycle's allocate lands, so releasing the tag being handed out is rejected.
  assign rel_fire = rel_ok && in_use[release_tag_i];
  assign rel_bad  = release_valid_i & ~rel_fire;
  always_comb begin
    rel_mask = '0;
    rel_mask[release_tag_i] = rel_fire;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      in_use            <= '0;
      err_double_free_o <= 1'b0;
      err_tag_o         <= '0;
    end else begin
      in_use            <= (in_use | (alloc_fire ? alloc_onehot_o : '0)) & ~rel_mask;
      err_double_free_o <= rel_bad;
      if (rel_bad) err_tag_o <= release_tag_i;
    end
  end
`else
  assign rel_fire          = rel_ok;
  assign err_double_free_o = 1'b0;
  assign err_tag_o         = '0;
`endif
endmodule

// File: tb/tb_stitch_sb_tag_pool.sv
// tb_stitch_sb_tag_pool: directed self-checking bench for an 8-tag and a 6-tag pool.
module tb_stitch_sb_tag_pool;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0, ready = 1'b0, rel_v = 1'b0;
  logic [2:0] rel_tag = '0;
  logic       valid, rel_rdy, almost, err;
  logic [2:0] tag, err_tag;
  logic [7:0] onehot;
  logic [3:0] cnt;
  logic       ready_b = 1'b0, rel_v_b = 1'b0;
  logic [2:0] rel_tag_b = '0;
  logic       valid_b, rel_rdy_b, almost_b, err_b;
  logic [2:0] tag_b, err_tag_b;
  logic [5:0] onehot_b;
  logic [3:0] cnt_b;
  int         n_cmp = 0, n_bad = 0;
`ifdef STITCH_SB_TAG_POOL_DOUBLE_FREE_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif
  always #5 clk_i = ~clk_i;
  stitch_sb_tag_pool #(.NumTags(8), .LowWater(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_o(valid), .alloc_ready_i(ready), .alloc_tag_o(tag), .alloc_onehot_o(onehot),
    .release_valid_i(rel_v), .release_tag_i(rel_tag), .release_ready_o(rel_rdy),
    .free_cnt_o(cnt), .almost_empty_o(almost), .err_double_free_o(err), .err_tag_o(err_tag)
  );
  stitch_sb_tag_pool #(.NumTags(6), .LowWater(1)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(1'b0),
    .alloc_valid_o(valid_b), .alloc_ready_i(ready_b), .alloc_tag_o(tag_b), .alloc_onehot_o(onehot_b),
    .release_valid_i(rel_v_b), .release_tag_i(rel_tag_b), .release_ready_o(rel_rdy_b),
    .free_cnt_o(cnt_b), .almost_empty_o(almost_b), .err_double_free_o(err_b), .err_tag_o(err_tag_b)
  );
  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    ready = 0; rel_v = 0; flush_i = 0; ready_b = 0; rel_v_b = 0;
    rst_ni = 0;
    step();
    step();
    rst_ni = 1;
  endtask
  initial begin
    int q[$];
    int prev, a;
    do_reset();
    chk("rst_valid", valid, 1);
    chk("rst_tag", tag, 0);
    chk("rst_onehot", onehot, 1);
    chk("rst_cnt", cnt, 8);
    chk("rst_almost", almost, 0);
    chk("rst_err", err, 0);
    chk("rst_err_tag", err_tag, 0);
    chk("rst_rel_rdy", rel_rdy, 1);
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", valid, 1);
      chk("drain_tag", tag, i);
      chk("drain_onehot", onehot, 1 << i);
      chk("drain_cnt", cnt, 8 - i);
      chk("drain_almost", almost, (8 - i) <= 1);
      step();
    end
    chk("empty_valid", valid, 0);
    chk("empty_onehot", onehot, 0);
    chk("empty_cnt", cnt, 0);
    chk("empty_almost", almost, 1);
    step();
    chk("empty9_cnt", cnt, 0);
    chk("empty9_valid", valid, 0);
    ready = 0; rel_v = 1; rel_tag = 5;
    step();
    chk("rel5_valid", valid, 1);
    chk("rel5_tag", tag, 5);
    chk("rel5_cnt", cnt, 1);
    ready = 1; rel_tag = 2;
    step();
    chk("rel2_tag", tag, 2);
    chk("rel2_cnt", cnt, 1);
    rel_v = 0;
    step();
    chk("take2_valid", valid, 0);
    rel_v = 1; rel_tag = 3;
    step();
    chk("bypass_tag", tag, 3);
    chk("bypass_cnt", cnt, 1);
    chk("bypass_valid", valid, 1);
    chk("bypass_err", err, 0);
    do_reset();
    ready = 1;
    step();
    ready = 0;
    chk("df_pre_cnt", cnt, 7);
    rel_v = 1; rel_tag = 4;
    step();
    rel_v = 0;
    chk("df_cnt", cnt, Chk ? 7 : 8);
    chk("df_err", err, Chk ? 1 : 0);
    chk("df_err_tag", err_tag, Chk ? 4 : 0);
    step();
    chk("df_pulse", err, 0);
    chk("df_hold_tag", err_tag, Chk ? 4 : 0);
    ready = 1;
    step();
    step();
    chk("pre_flush_cnt", cnt, Chk ? 5 : 6);
    flush_i = 1; rel_v = 1; rel_tag = 1;
    step();
    flush_i = 0; rel_v = 0; ready = 0;
    chk("flush_cnt", cnt, 8);
    chk("flush_tag", tag, 0);
    chk("flush_onehot", onehot, 1);
    chk("flush_err", err, 0);
    chk("flush_err_tag", err_tag, 0);
    rel_v = 1; rel_tag = 3;
    step();
    rel_v = 0;
    chk("full_rel_cnt", cnt, 8);
    chk("full_rel_err", err, Chk ? 1 : 0);
    chk("full_rel_err_tag", err_tag, Chk ? 3 : 0);
    do_reset();
    q = '{0, 1, 2, 3, 4, 5};
    prev = -1;
    for (int c = 0; c < 20; c++) begin
      chk("wrap_tag", tag_b, q[0]);
      chk("wrap_cnt", cnt_b, q.size());
      chk("wrap_onehot", onehot_b, 1 << q[0]);
      ready_b = 1;
      rel_v_b = prev >= 0;
      rel_tag_b = (prev >= 0) ? 3'(prev) : 3'd0;
      step();
      a = q.pop_front();
      if (prev >= 0) q.push_back(prev);
      prev = a;
    end
    ready_b = 0; rel_v_b = 0;
    chk("wrap_end_cnt", cnt_b, q.size());
    rel_v_b = 1; rel_tag_b = 7;
    step();
    rel_v_b = 0;
    chk("oor_cnt", cnt_b, q.size());
    chk("oor_err", err_b, Chk ? 1 : 0);
    chk("oor_err_tag", err_tag_b, Chk ? 7 : 0);
    chk("oor_tag", tag_b, q[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
